// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field encoder feeding a 2-entry address-tagged output queue
// Optional immediate range flagging is compiled in when IMM_CHECK_EN is defined.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [2:0]  FMT_R    = 3'd0;
  localparam logic [2:0]  FMT_I    = 3'd1;
  localparam logic [2:0]  FMT_S    = 3'd2;
  localparam logic [2:0]  FMT_B    = 3'd3;
  localparam logic [2:0]  FMT_U    = 3'd4;
  localparam logic [2:0]  FMT_J    = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } q_state_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  q_state_e          state_q, state_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              push;
  logic              pop;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              imm_bad;
  entry_t            new_entry;
  entry_t            reset_entry;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Field packing; formats outside R..J fall back to a NOP and raise the error flag.
  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: enc_word = {imm[31:12], rd, opcode};
      FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

`ifdef IMM_CHECK_EN
  // An immediate is in range when every bit above the format's sign bit matches it.
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = (imm[31:11] != {21{imm[11]}});
      FMT_B:        imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J:        imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:        imm_bad = (imm[11:0] != 12'h000);
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign new_entry   = '{instr: enc_word, addr: pc_q, err: enc_illegal | imm_bad};
  assign reset_entry = '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= Q_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_TWO;
        else if (pop && !push) state_d = Q_EMPTY;
      end
      Q_TWO:   if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      Q_EMPTY: in_ready = 1'b1;
      Q_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      Q_TWO:   out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Head slot always drives the outputs; the tail only holds the second word while full.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      Q_EMPTY: if (push) head_d = new_entry;
      Q_ONE: begin
        if (push && pop) head_d = new_entry;
        else if (push)   tail_d = new_entry;
      end
      Q_TWO:   if (pop) head_d = tail_q;
      default: head_d = head_q;
    endcase
  end

  assign pc_d = push ? pc_q + ADDR_W'(4) : pc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_q <= reset_entry;
      tail_q <= reset_entry;
      pc_q   <= BASE_ADDR;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      pc_q   <= pc_d;
    end
  end

  assign out_instr = head_q.instr;
  assign out_addr  = head_q.addr;
  assign out_err   = head_q.err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder against a field-packing model
module tb_instr_encoder;

  localparam int unsigned   AW   = 4;
  localparam logic [AW-1:0] BASE = 4'd4;
`ifdef IMM_CHECK_EN
  localparam bit IMMCHK = 1'b1;
`else
  localparam bit IMMCHK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  logic [AW-1:0] model_pc = BASE;
  bit            started = 1'b0;
  bit            use_dir = 1'b0;
  logic [31:0]   dir_instr = 32'h0;
  bit            dir_err = 1'b0;

  // Bit-placement model: each field is masked and shifted to its documented position.
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] d, input logic [31:0] im);
    logic [31:0] w;
    bit          bad;
    longint      s;
    s   = longint'($signed(im));
    bad = 1'b0;
    case (f)
      3'd0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
      3'd1: begin
        w   = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w   = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
            | ((im & 32'h1F) << 7) | op;
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w   = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
            | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
            | (((im >> 11) & 1) << 7) | op;
        bad = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      3'd4: begin
        w   = (im & 32'hFFFF_F000) | (d << 7) | op;
        bad = (im % 4096) != 0;
      end
      3'd5: begin
        w   = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
            | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
        bad = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
      end
      default: w = 32'h0000_0013;
    endcase
    return {(f > 3'd5) || (IMMCHK && bad), w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: records the expected word for every handshake the DUT takes.
  always @(posedge clk) begin : sampler
    logic [32:0] r;
    if (rst || clr) begin
      exp_q.delete();
      model_pc <= BASE;
    end else if (started && in_valid && in_ready) begin
      r = use_dir ? {dir_err, dir_instr}
                  : ref_encode(fmt, 32'(opcode), 32'(funct3), 32'(funct7),
                               32'(rs1), 32'(rs2), 32'(rd), imm);
      exp_q.push_back('{instr: r[31:0], addr: model_pc, err: r[32]});
      model_pc <= model_pc + 4'd4;
      acc_cnt  <= acc_cnt + 1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (started && !rst && !clr) begin
      check("out_valid_vs_depth", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready_vs_depth", 32'(in_ready), 32'(exp_q.size() < 2));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %h expected none", out_instr);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_addr", 32'(out_addr), 32'(e.addr));
          check("out_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  task automatic rand_fields();
    int v;
    fmt    = 3'($urandom_range(0, 7));
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    rd     = 5'($urandom);
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: begin v = int'($urandom_range(0, 8191)) - 4096; imm = v; end
      2: begin v = int'($urandom_range(0, 4194303)) - 2097152; imm = v & ~1; end
      default: imm = $urandom << 12;
    endcase
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
      input logic [31:0] im, input logic [31:0] ei, input bit ee);
    int n0;
    int t;
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = d; imm = im;
    dir_instr = ei; dir_err = ee; use_dir = 1'b1;
    in_valid = 1'b1;
    n0 = acc_cnt;
    t  = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (acc_cnt == n0 && t < 50);
    checks++;
    if (acc_cnt == n0) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    in_valid = 1'b0;
    use_dir  = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_addr"}, 32'(out_addr), 32'(BASE));
    check({tag, "_out_instr"}, out_instr, 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
  endtask

  // Fill the queue (TWO, or ONE when two_deep=0), then flush with rst or clr.
  task automatic flush_test(input bit use_rst, input bit two_deep, input string tag);
    int n0;
    out_ready = 1'b0;
    use_dir   = 1'b0;
    n0 = acc_cnt;
    rand_fields();
    in_valid = 1'b1;
    repeat (two_deep ? 2 : 1) begin
      @(posedge clk); #1;
      rand_fields();
    end
    check({tag, "_filled"}, 32'(acc_cnt - n0), two_deep ? 32'd2 : 32'd1);
    out_ready = 1'b1;
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
    check_idle(tag);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
    drain();
  endtask

  initial begin : stim
    int n0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = 3'd0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; imm = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check_idle("reset");

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
    check("latency_valid", 32'(out_valid), 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd9, 5'd5, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
    send(3'd2, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd7, 32'd8, 32'h0020A423, 1'b0);
    send(3'd5, 7'h6F, 3'd5, 7'd0, 5'd3, 5'd4, 5'd1, 32'd8, 32'h008000EF, 1'b0);
    send(3'd7, 7'h33, 3'd1, 7'd1, 5'd1, 5'd2, 5'd3, 32'd4, 32'h00000013, 1'b1);
    send(3'd6, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h800, 32'h80000013, IMMCHK);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h00000163, IMMCHK);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h12345000, 32'h123450B7, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h12345678, 32'h123450B7, IMMCHK);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd6, 5'd7, 5'd0, 32'hFFFF_F000, 32'h80731063, 1'b0);
    drain();

    // Backpressure: three offers with the consumer stalled, only two fit.
    out_ready = 1'b0;
    n0 = acc_cnt;
    rand_fields();
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      rand_fields();
    end
    check("bp_accepts", 32'(acc_cnt - n0), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();

    // Streaming through the ONE state sustains one word per cycle.
    out_ready = 1'b1;
    n0 = acc_cnt;
    rand_fields();
    in_valid = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      rand_fields();
    end
    in_valid = 1'b0;
    check("throughput", 32'(acc_cnt - n0), 32'd16);
    drain();

    flush_test(1'b1, 1'b1, "rst_two");
    flush_test(1'b0, 1'b1, "clr_two");
    flush_test(1'b0, 1'b0, "clr_one");

    for (int i = 0; i < 500; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction field encoder, the inverse of the field decoder. It packs opcode/funct3/funct7/rs1/rs2/rd/immediate into a 32-bit instruction word according to a selected format (R/I/S/B/U/J).
- Sits between the test-program generator/loader and instruction memory.
- Accepted words are buffered in a 2-entry output queue with valid/ready handshakes. Each word is tagged with a byte address from an internal program counter.

Parameters:
- ADDR_W, 32, width of the address counter and of out_addr.
- BASE_ADDR, 0, byte address assigned after reset or clear; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous clear: empties the queue and reloads the counter to BASE_ADDR.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12] (R/I/S/B).
- funct7  in  7  instruction[31:25] (R only).
- rs1  in  5  source register 1 (R/I/S/B).
- rs2  in  5  source register 2 (R/S/B).
- rd  in  5  destination register (R/I/U/J).
- imm  in  32  immediate as a signed byte value; U uses imm[31:12].
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts the head word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_err  out  1  head word came from an illegal fmt (or a range violation, see Optional Feature).

Behaviour:
- Reset (rst=1) and clr=1 have identical effect:
  - queue count=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, in_ready=1, counter=BASE_ADDR.
  - rst has priority over everything.
  - Any handshake in the same cycle as rst or clr is discarded.
  - Reset mid-stream drops every buffered word.
- Input handshake: a field set is accepted when in_valid && in_ready.
- in_ready = (count<2). It is a registered state decode and never depends combinationally on out_ready.
- Output handshake: the head word pops when out_valid && out_ready.
- out_valid = (count>0). out_instr, out_addr and out_err always show the head entry. Outputs hold stable while out_valid && !out_ready.
- Latency: a word accepted at edge N is visible on the outputs after edge N (one cycle). There is no combinational bypass from inputs to outputs.
- Queue states and transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE, with the new word becoming head in order.
  - TWO: pop -> ONE; no push is possible because in_ready=0.
  - Strict FIFO order.
- Address counter: each accepted word is tagged with the current counter, then the counter increments by 4 modulo 2^ADDR_W. Wrap from all-ones-minus-3 to 0 is silent.
- Encoding, MSB..LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Fields unused by a format are ignored.
- Out-of-range immediate bits are truncated silently. imm[0] for B/J is dropped.
- Illegal fmt (6,7): the word is encoded as NOP 0x00000013 with out_err=1. It still consumes an address.

Optional Feature:
- Macro IMM_CHECK_EN.
- Defined: out_err is also set for a word when any of the following holds:
  - I/S imm is not the sign-extension of imm[11:0].
  - B imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - J imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U imm[11:0] is nonzero.
- Defined: the encoded word is unchanged (truncated as normal); only the flag differs.
- Undefined: out_err reflects illegal fmt only, and the check logic is absent.

Test Plan:
- R add x3,x1,x2 (fmt=0, op=0x33, f3=0, f7=0) -> out_instr=0x002081B3, out_addr=BASE_ADDR, out_valid one cycle after acceptance.
- I addi x5,x0,-1 (fmt=1, op=0x13, imm=0xFFFFFFFF) -> 0xFFF00293; then S sw x2,8(x1) (fmt=2, op=0x23, f3=2, imm=8) -> 0x0020A423 at addr +4.
- J jal x1,8 (fmt=5, op=0x6F, imm=8) -> 0x008000EF. Illegal fmt=7 -> 0x00000013 with out_err=1.
- Backpressure:
  - Hold out_ready=0 and offer 3 words -> in_ready=0 after 2 are accepted.
  - Raise out_ready -> words exit in order at addrs 0,4,8 with no loss or duplication.
  - Push+pop in the ONE state each cycle -> sustained throughput of 1 word/cycle.
- With queue=TWO, assert rst (and separately clr) -> next cycle out_valid=0, in_ready=1; the next accepted word gets addr=BASE_ADDR. Also preset ADDR_W=4 and verify counter wrap 12->0.
- IMM_CHECK_EN: I imm=0x800 -> out_err=1, word 0x80000013 for addi x0,x0; B imm=3 -> out_err=1. Without the macro, the same stimulus gives out_err=0.
